wb_redirect_ctrl: RTL and testbench

Sequencer that turns a flush-causing instruction retiring at writeback (CSR write, `mret`, trap or interrupt) into an orderly pipeline flush and PC redirect. It sits beside the writeback stage. It freezes the pipeline, waits for outstanding instruction and data bus transactions to finish, then issues a one-cycle flush and redirect. It holds the stall for a programmable settle period before releasing the pipeline.

---
 rtl/wb_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_wb_redirect_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_redirect_ctrl.sv
// Writeback redirect sequencer: freezes the pipeline on a flush-causing retire,
// drains outstanding bus traffic, then issues a single flush/redirect pulse and a settle hold.
module wb_redirect_ctrl #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_kind,
    input  logic [63:0] req_pc,
    input  logic [63:0] mepc,
    input  logic [63:0] mtvec,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    output logic        stall_out,
    output logic        flush_out,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        busy
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] target;
    logic [7:0]  hold_cnt;
    logic        bus_busy;
    logic        accept;

    assign bus_busy = ibus_busy | dbus_busy;
    assign accept   = (state == S_IDLE) & req_valid;

    // Kind 3 is reserved and deliberately shares the trap vector path.
    function automatic logic [63:0] select_target(
        input logic [1:0]  kind,
        input logic [63:0] pc,
        input logic [63:0] epc,
        input logic [63:0] tvec
    );
        case (kind)
            2'd0:    return pc + 64'd4;
            2'd1:    return epc;
            default: return {tvec[63:2], 2'b00};
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Target is captured only at the accept edge so later CSR updates cannot leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target   <= '0;
            hold_cnt <= '0;
        end else begin
            if (accept) begin
                target <= select_target(req_kind, req_pc, mepc, mtvec);
            end
            if (state == S_FLUSH) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = bus_busy ? S_DRAIN : S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (!bus_busy) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nxt = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == 8'd1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall asserts combinationally in the accept cycle; reset forces it low at once.
    always_comb begin
        busy           = (state != S_IDLE);
        stall_out      = busy | ((state == S_IDLE) & req_valid & ~reset);
        flush_out      = (state == S_FLUSH);
        redirect_valid = (state == S_FLUSH);
        redirect_pc    = (state == S_FLUSH) ? target : 64'd0;
    end

endmodule

// File: tb/tb_wb_redirect_ctrl.sv
// Bench for wb_redirect_ctrl: three instances (hold 1, 0, 3) share stimulus and are
// compared every cycle against a countdown-style reference model.
module tb_wb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_kind = 2'd0;
    logic [63:0] req_pc = 64'd0;
    logic [63:0] mepc = 64'd0;
    logic [63:0] mtvec = 64'd0;
    logic        ibus_busy = 1'b0;
    logic        dbus_busy = 1'b0;

    logic        stall [3];
    logic        flush [3];
    logic        rvld  [3];
    logic [63:0] rpc   [3];
    logic        bsy   [3];

    int total = 0;
    int bad = 0;

    bit          m_wait [3];
    bit          m_fl   [3];
    int          m_hold [3];
    logic [63:0] m_tgt  [3];

    always #5 clk = ~clk;

    wb_redirect_ctrl #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
        .req_pc(req_pc), .mepc(mepc), .mtvec(mtvec), .ibus_busy(ibus_busy),
        .dbus_busy(dbus_busy), .stall_out(stall[0]), .flush_out(flush[0]),
        .redirect_valid(rvld[0]), .redirect_pc(rpc[0]), .busy(bsy[0])
    );

    wb_redirect_ctrl #(.HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
        .req_pc(req_pc), .mepc(mepc), .mtvec(mtvec), .ibus_busy(ibus_busy),
        .dbus_busy(dbus_busy), .stall_out(stall[1]), .flush_out(flush[1]),
        .redirect_valid(rvld[1]), .redirect_pc(rpc[1]), .busy(bsy[1])
    );

    wb_redirect_ctrl #(.HOLD_CYCLES(3)) dut_h3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
        .req_pc(req_pc), .mepc(mepc), .mtvec(mtvec), .ibus_busy(ibus_busy),
        .dbus_busy(dbus_busy), .stall_out(stall[2]), .flush_out(flush[2]),
        .redirect_valid(rvld[2]), .redirect_pc(rpc[2]), .busy(bsy[2])
    );

    function automatic int hold_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [63:0] ref_target(input logic [1:0] k, input logic [63:0] pc,
                                               input logic [63:0] ep, input logic [63:0] tv);
        if (k == 2'd0) return pc + 64'd4;
        if (k == 2'd1) return ep;
        return (tv >> 2) << 2;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_wait[i] = 0;
            m_fl[i]   = 0;
            m_hold[i] = 0;
            m_tgt[i]  = 64'd0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            bit act;
            act = m_wait[i] || m_fl[i] || (m_hold[i] > 0);
            chk("busy", i, 64'(bsy[i]), 64'(act));
            chk("stall", i, 64'(stall[i]), 64'(act || (req_valid && !reset)));
            chk("flush", i, 64'(flush[i]), 64'(m_fl[i]));
            chk("redirect_valid", i, 64'(rvld[i]), 64'(m_fl[i]));
            chk("redirect_pc", i, rpc[i], m_fl[i] ? m_tgt[i] : 64'd0);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!(m_wait[i] || m_fl[i] || (m_hold[i] > 0))) begin
                if (req_valid) begin
                    m_tgt[i] = ref_target(req_kind, req_pc, mepc, mtvec);
                    if (ibus_busy || dbus_busy) m_wait[i] = 1;
                    else                        m_fl[i] = 1;
                end
            end else if (m_wait[i]) begin
                if (!(ibus_busy || dbus_busy)) begin
                    m_wait[i] = 0;
                    m_fl[i]   = 1;
                end
            end else if (m_fl[i]) begin
                m_fl[i]   = 0;
                m_hold[i] = hold_of(i);
            end else begin
                m_hold[i]--;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic [1:0] k, input logic [63:0] pc,
                         input logic ib, input logic db);
        req_valid = r;
        req_kind  = k;
        req_pc    = pc;
        ibus_busy = ib;
        dbus_busy = db;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1 check_all();
        @(posedge clk);
        #1 reset = 1'b0;

        // CSR write, bus idle
        drive(1, 2'd0, 64'h8000_0010, 0, 0); cycle();
        drive(0, 2'd0, 64'd0, 0, 0);         repeat (5) cycle();

        // Trap with drain; mtvec changes after accept
        mtvec = 64'h8000_0103;
        drive(1, 2'd2, 64'h10, 0, 1); cycle();
        drive(0, 2'd0, 64'd0, 0, 1);  cycle();
        mtvec = 64'd0;                repeat (3) cycle();
        drive(0, 2'd0, 64'd0, 0, 0);  repeat (6) cycle();

        // mret then back-to-back request
        mepc = 64'h8000_2000;
        drive(1, 2'd1, 64'h40, 0, 0);  cycle();
        drive(0, 2'd0, 64'd0, 0, 0);   cycle();
        drive(1, 2'd0, 64'h100, 0, 0); cycle();
        drive(0, 2'd0, 64'd0, 0, 0);   repeat (6) cycle();

        // Requests during DRAIN and HOLD, busy toggling inside DRAIN
        drive(1, 2'd0, 64'h1000, 1, 0); cycle();
        drive(1, 2'd1, 64'h2000, 1, 0); cycle();
        drive(0, 2'd0, 64'd0, 0, 0);    cycle();
        drive(0, 2'd0, 64'd0, 1, 1);    cycle();
        drive(1, 2'd3, 64'h3000, 0, 0); cycle();
        drive(1, 2'd2, 64'h4000, 0, 0); cycle();
        drive(0, 2'd0, 64'd0, 0, 0);    repeat (6) cycle();

        // Asynchronous reset in the middle of DRAIN
        drive(1, 2'd0, 64'h5000, 1, 0); cycle();
        drive(0, 2'd0, 64'd0, 1, 0);    cycle();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 2'd0, 64'd0, 0, 0);    repeat (5) cycle();

        // PC+4 wrap-around
        drive(1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0); cycle();
        drive(0, 2'd0, 64'd0, 0, 0);                   repeat (5) cycle();

        // Randomized traffic
        repeat (600) begin
            mepc  = {$urandom, $urandom};
            mtvec = {$urandom, $urandom};
            drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
